// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch unit and the control unit.
//   PC_* : next-PC select codes driven by the control unit on pcsource.
//   state_e : fetch unit FSM encoding.
//   RESET_PC_DEFAULT : default program counter after reset.
package mips_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] PC_BR  = 2'b01;  // pc + 4 + (sext(off) << 2)
  localparam logic [1:0] PC_JR  = 2'b10;  // register target
  localparam logic [1:0] PC_J   = 2'b11;  // pseudo-direct jump / jal

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction memory request/acknowledge bus.
//   req   : fetch request, held until ack
//   addr  : word address of the fetch, stable while req is high
//   ack   : rdata is valid in this cycle
//   rdata : fetched instruction word
// master = fetch unit side, slave = instruction memory side.
interface ifu_fetch_if;

  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );

endinterface

// File: rtl/npc_calc.sv
// Combinational next-PC selection.
//   pc            : current program counter
//   pcsource      : select code (PC_SEQ / PC_BR / PC_JR / PC_J)
//   br_off        : instr[15:0], signed word offset relative to pc + 4
//   j_target      : instr[25:0], word index inside the low 256 MiB
//   jr_addr       : register value for jr
//   npc           : selected next PC, wraps modulo 2^32
//   jr_misaligned : jr is selected and jr_addr is not word aligned
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pcsource,
  input  logic [15:0] br_off,
  input  logic [25:0] j_target,
  input  logic [31:0] jr_addr,
  output logic [31:0] npc,
  output logic        jr_misaligned
);

  logic [31:0] pc_seq;
  logic [31:0] br_disp;

  assign pc_seq  = pc + 32'd4;
  assign br_disp = {{14{br_off[15]}}, br_off, 2'b00};

  always_comb begin
    npc           = pc_seq;
    jr_misaligned = 1'b0;
    case (pcsource)
      PC_SEQ: npc = pc_seq;
      PC_BR:  npc = pc_seq + br_disp;
      PC_JR: begin
        // Low bits are dropped so the PC stays word aligned; the caller flags it.
        npc           = {jr_addr[31:2], 2'b00};
        jr_misaligned = |jr_addr[1:0];
      end
      PC_J:   npc = {4'b0000, j_target, 2'b00};
      default: npc = pc_seq;
    endcase
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches over the imem bus into the
// instruction register, presents it for one execute phase and then advances
// the PC according to the control unit's pcsource.
//   clk, rst    : clock and synchronous active-high reset
//   pcsource    : next-PC select, sampled on the advancing edge only
//   br_off      : branch offset field
//   j_target    : jump field
//   jr_addr     : jr register target
//   stall       : holds the execute phase
//   imem        : instruction memory bus (master side)
//   instr       : instruction register
//   instr_valid : instr is being executed this cycle
//   pc          : current PC
//   pc_plus4    : pc + 4 (jal link value)
//   retired     : completed instruction count, wraps
//   align_err   : sticky, a jr targeted a non word-aligned address
module ifu_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       pcsource,
  input  logic [15:0]      br_off,
  input  logic [25:0]      j_target,
  input  logic [31:0]      jr_addr,
  input  logic             stall,
  ifu_fetch_if.master      imem,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [CNT_W-1:0] retired,
  output logic             align_err
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             align_err_q, align_err_d;

  logic [31:0] npc;
  logic        jr_misaligned;
  logic        advance;

  npc_calc u_npc_calc (
    .pc            (pc_q),
    .pcsource      (pcsource),
    .br_off        (br_off),
    .j_target      (j_target),
    .jr_addr       (jr_addr),
    .npc           (npc),
    .jr_misaligned (jr_misaligned)
  );

  assign advance = (state_q == S_EXEC) && !stall;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    retired_d   = retired_q;
    align_err_d = align_err_q;
    case (state_q)
      S_FETCH: begin
        if (imem.ack) begin
          instr_d = imem.rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // ack is ignored here; only stall can hold the instruction.
        if (advance) begin
          pc_d        = npc;
          retired_d   = retired_q + CNT_W'(1);
          align_err_d = align_err_q | jr_misaligned;
          state_d     = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      retired_q   <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      retired_q   <= retired_d;
      align_err_q <= align_err_d;
    end
  end

  // Masked by rst so nothing is requested or presented during the reset cycle.
  assign imem.req    = (state_q == S_FETCH) && !rst;
  assign imem.addr   = pc_q;
  assign instr_valid = (state_q == S_EXEC) && !rst;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign retired     = retired_q;
  assign align_err   = align_err_q;

endmodule
